instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/instr_fetch_if.sv | 46 ++++
 rtl/instr_mem.sv | 40 ++++
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU types: instruction width, instruction class codes
//               and the fetch-unit state encoding.
// Revision    : 1.0
// ============================================================================
package cpu_pkg;

    localparam int unsigned C_INSTR_WIDTH = 20;

    typedef enum logic [1:0] {
        CLS_HALT    = 2'b00,
        CLS_STD_OP  = 2'b01,
        CLS_LOAD_R  = 2'b10,
        CLS_STORE_R = 2'b11
    } instr_class_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Control, program-load and instruction bus of the fetch unit.
//               IFETCH_JUMP_EN adds jump_en / jump_addr.
// Revision    : 1.0
// ============================================================================
interface instr_fetch_if
    import cpu_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = C_INSTR_WIDTH,
    parameter int unsigned PC_BITS     = 5
);
    logic                   start;
    logic                   prog_wen;
    logic [PC_BITS-1:0]     prog_addr;
    logic [INSTR_WIDTH-1:0] prog_data;
    logic                   next;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instr_valid;
    logic [PC_BITS-1:0]     pc;
    logic                   halted;
`ifdef IFETCH_JUMP_EN
    logic                   jump_en;
    logic [PC_BITS-1:0]     jump_addr;

    modport master (
        output start, prog_wen, prog_addr, prog_data, next, jump_en, jump_addr,
        input  instruction, instr_valid, pc, halted
    );
    modport slave (
        input  start, prog_wen, prog_addr, prog_data, next, jump_en, jump_addr,
        output instruction, instr_valid, pc, halted
    );
`else
    modport master (
        output start, prog_wen, prog_addr, prog_data, next,
        input  instruction, instr_valid, pc, halted
    );
    modport slave (
        input  start, prog_wen, prog_addr, prog_data, next,
        output instruction, instr_valid, pc, halted
    );
`endif
endinterface
`default_nettype wire

// File: rtl/instr_mem.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem
// Description : 2**PC_BITS x INSTR_WIDTH program store, synchronous write and
//               synchronous read, write-first on a same-address collision.
// Revision    : 1.0
// ============================================================================
module instr_mem
    import cpu_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = C_INSTR_WIDTH,
    parameter int unsigned PC_BITS     = 5
) (
    input  wire logic                   clk,
    input  wire logic                   wen,
    input  wire logic [PC_BITS-1:0]     waddr,
    input  wire logic [INSTR_WIDTH-1:0] wdata,
    input  wire logic                   ren,
    input  wire logic [PC_BITS-1:0]     raddr,
    output      logic [INSTR_WIDTH-1:0] rdata
);
    localparam int unsigned C_DEPTH = 1 << PC_BITS;

    logic [INSTR_WIDTH-1:0] mem_q [0:C_DEPTH-1];
    logic [INSTR_WIDTH-1:0] rdata_q;

    // No reset: program contents survive a fetch-unit reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[waddr] <= wdata;
        end
        if (ren) begin
            rdata_q <= (wen && (waddr == raddr)) ? wdata : mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch FSM and program counter in front of
//               instr_mem. Define IFETCH_JUMP_EN to enable jump_en/jump_addr.
// Revision    : 1.0
// ============================================================================
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = C_INSTR_WIDTH,
    parameter int unsigned PC_BITS     = 5
) (
    input  wire logic     clk,
    input  wire logic     rst,
    instr_fetch_if.slave  bus
);
    localparam logic [PC_BITS-1:0] C_PC_ONE = {{(PC_BITS-1){1'b0}}, 1'b1};

    fetch_state_t           state_q, state_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instruction_q, instruction_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   halted_q, halted_d;

    logic                   w_mem_wen;
    logic                   w_mem_ren;
    logic [INSTR_WIDTH-1:0] w_mem_rdata;
    instr_class_t           w_class;

    assign w_mem_wen = bus.prog_wen && ((state_q == ST_IDLE) || (state_q == ST_HALT));
    // Read is launched on the edge entering FETCH, so data is ready at its end.
    assign w_mem_ren = (state_d == ST_FETCH);
    assign w_class   = instr_class_t'(w_mem_rdata[INSTR_WIDTH-1 -: 2]);

    instr_mem #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .PC_BITS     (PC_BITS)
    ) u_mem (
        .clk   (clk),
        .wen   (w_mem_wen),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .ren   (w_mem_ren),
        .raddr (pc_d),
        .rdata (w_mem_rdata)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instruction_d = instruction_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    state_d  = ST_FETCH;
                    pc_d     = '0;
                    halted_d = 1'b0;
                end
            end
            ST_FETCH: begin
`ifdef IFETCH_JUMP_EN
                if (bus.jump_en) begin
                    pc_d = bus.jump_addr;
                end else
`endif
                if (w_class == CLS_HALT) begin
                    state_d       = ST_HALT;
                    instruction_d = '0;
                    instr_valid_d = 1'b0;
                    halted_d      = 1'b1;
                end else begin
                    state_d       = ST_VALID;
                    instruction_d = w_mem_rdata;
                    instr_valid_d = 1'b1;
                end
            end
            ST_VALID: begin
`ifdef IFETCH_JUMP_EN
                if (bus.jump_en) begin
                    state_d       = ST_FETCH;
                    pc_d          = bus.jump_addr;
                    instr_valid_d = 1'b0;
                end else
`endif
                if (bus.next) begin
                    state_d       = ST_FETCH;
                    pc_d          = pc_q + C_PC_ONE;
                    instr_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            instruction_q <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign bus.instruction = instruction_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
    assign bus.halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch; the jump case
//               is included when IFETCH_JUMP_EN is defined.
// Revision    : 1.0
// ============================================================================
module tb_instr_fetch;
    localparam int unsigned IW = 20;
    localparam int unsigned PB = 5;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [IW+PB+1:0] obs;
    logic [IW+PB+1:0] exp;

    instr_fetch_if #(.INSTR_WIDTH(IW), .PC_BITS(PB)) bus ();

    instr_fetch #(.INSTR_WIDTH(IW), .PC_BITS(PB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign obs = {bus.instruction, bus.instr_valid, bus.pc, bus.halted};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [IW+PB+1:0] pack(input logic [IW-1:0] ins, input logic v,
                                              input logic [PB-1:0] p, input logic h);
        return {ins, v, p, h};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [PB-1:0] a, input logic [IW-1:0] d);
        bus.prog_wen  = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        tick();
        bus.prog_wen  = 1'b0;
    endtask

    task automatic pulse_next();
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        exp = pack(20'h0, 1'b0, 5'd0, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_state: got=%h want=%h", obs, exp); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch_seq();
        write_word(5'd0, 20'h40010);
        write_word(5'd1, 20'h50020);
        write_word(5'd2, 20'h00000);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp = pack(20'h0, 1'b0, 5'd0, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL fetch_bubble: got=%h want=%h", obs, exp); end
        tick();
        exp = pack(20'h40010, 1'b1, 5'd0, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL first_word: got=%h want=%h", obs, exp); end
        tick();
        tick();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL hold_valid: got=%h want=%h", obs, exp); end
        pulse_next();
        exp = pack(20'h40010, 1'b0, 5'd1, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL bubble1: got=%h want=%h", obs, exp); end
        tick();
        exp = pack(20'h50020, 1'b1, 5'd1, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL second_word: got=%h want=%h", obs, exp); end
        pulse_next();
        exp = pack(20'h50020, 1'b0, 5'd2, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL bubble2: got=%h want=%h", obs, exp); end
        tick();
        exp = pack(20'h0, 1'b0, 5'd2, 1'b1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL halt: got=%h want=%h", obs, exp); end
        pulse_next();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL halt_ignores_next: got=%h want=%h", obs, exp); end
    endtask

    task automatic test_write_guard();
        write_word(5'd3, 20'h40033);
        write_word(5'd4, 20'h00000);
        write_word(5'd2, 20'h4AAAA);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        write_word(5'd3, 20'h7FFFF);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp = pack(20'h40010, 1'b1, 5'd0, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL start_ignored_valid: got=%h want=%h", obs, exp); end
        pulse_next();
        tick();
        exp = pack(20'h50020, 1'b1, 5'd1, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL guard_word1: got=%h want=%h", obs, exp); end
        pulse_next();
        tick();
        exp = pack(20'h4AAAA, 1'b1, 5'd2, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL halt_write_taken: got=%h want=%h", obs, exp); end
        pulse_next();
        tick();
        exp = pack(20'h40033, 1'b1, 5'd3, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL valid_write_dropped: got=%h want=%h", obs, exp); end
        pulse_next();
        tick();
        exp = pack(20'h0, 1'b0, 5'd4, 1'b1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL halt_at_4: got=%h want=%h", obs, exp); end
    endtask

    task automatic test_reset_mid();
        write_word(5'd2, 20'h00000);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        pulse_next();
        rst = 1'b0;
        #1;
        exp = pack(20'h0, 1'b0, 5'd0, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL async_reset: got=%h want=%h", obs, exp); end
        #2;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL idle_after_reset: got=%h want=%h", obs, exp); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        exp = pack(20'h40010, 1'b1, 5'd0, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL replay0: got=%h want=%h", obs, exp); end
        pulse_next();
        tick();
        exp = pack(20'h50020, 1'b1, 5'd1, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL replay1: got=%h want=%h", obs, exp); end
        pulse_next();
        tick();
        exp = pack(20'h0, 1'b0, 5'd2, 1'b1);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL replay_halt: got=%h want=%h", obs, exp); end
    endtask

    task automatic test_wrap();
        for (int i = 1; i < 31; i++) begin
            write_word(PB'(i), IW'(32'h40000 | i));
        end
        write_word(5'd31, 20'h40000);
        bus.prog_wen  = 1'b1;
        bus.prog_addr = 5'd0;
        bus.prog_data = 20'h80000;
        bus.start     = 1'b1;
        tick();
        bus.prog_wen  = 1'b0;
        bus.start     = 1'b0;
        tick();
        exp = pack(20'h80000, 1'b1, 5'd0, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL write_start_same_cycle: got=%h want=%h", obs, exp); end
        for (int i = 1; i < 32; i++) begin
            pulse_next();
            tick();
            exp = pack(IW'((i == 31) ? 32'h40000 : (32'h40000 | i)), 1'b1, PB'(i), 1'b0);
            total++;
            if (obs !== exp) begin bad++; $display("FAIL walk_%0d: got=%h want=%h", i, obs, exp); end
        end
        pulse_next();
        exp = pack(20'h40000, 1'b0, 5'd0, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL wrap_bubble: got=%h want=%h", obs, exp); end
        tick();
        exp = pack(20'h80000, 1'b1, 5'd0, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL wrap_word: got=%h want=%h", obs, exp); end
    endtask

`ifdef IFETCH_JUMP_EN
    task automatic test_jump();
        bus.next      = 1'b1;
        bus.jump_en   = 1'b1;
        bus.jump_addr = 5'd5;
        tick();
        bus.next      = 1'b0;
        bus.jump_en   = 1'b0;
        exp = pack(20'h80000, 1'b0, 5'd5, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL jump_bubble: got=%h want=%h", obs, exp); end
        tick();
        exp = pack(20'h40005, 1'b1, 5'd5, 1'b0);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL jump_word: got=%h want=%h", obs, exp); end
    endtask
`endif

    initial begin
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.prog_wen  = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.next      = 1'b0;
`ifdef IFETCH_JUMP_EN
        bus.jump_en   = 1'b0;
        bus.jump_addr = '0;
`endif
        test_reset();
        test_fetch_seq();
        test_write_guard();
        test_reset_mid();
        test_wrap();
`ifdef IFETCH_JUMP_EN
        test_jump();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
